// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-code sync monitor.
//   mon_state_e  : monitor FSM states (acquire, verify, locked)
//   gray2bin     : gray-to-binary decode; works for any width up to MaxWidth
//                  when the gray value is zero-extended
//   err_cnt_max  : all-ones maximum of a saturating counter of a given width
package gray_pkg;

  typedef enum logic [1:0] {
    StAcquire,
    StVerify,
    StLocked
  } mon_state_e;

  localparam int unsigned MaxWidth = 32;

  // Zero upper bits contribute nothing to the running XOR, so a narrower
  // value decodes correctly in the low bits.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b = '0;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [63:0] err_cnt_max(input int unsigned w);
    return (64'(1) << w) - 64'(1);
  endfunction

endpackage

// File: rtl/gray_sync_monitor_sync.sv
// Multi-bit flop chain that brings gray_in into the local clock domain.
// Gray coding guarantees at most one bit changes per step, so a per-bit
// synchroniser yields either the old or the new value, never a mix.
//   clk   : local clock
//   rst   : asynchronous active-high reset, clears every stage
//   d     : asynchronous gray input
//   q     : output of the last stage
module gray_sync
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_sync_monitor.sv
// Synchronises a gray-coded count, decodes it to binary and checks that every
// change is a legal +1 step (mod 2^WIDTH). Tracks lock and wrap-around and
// keeps a saturating count of sequence errors.
// Optional macro GRAY_MON_DOWN_EN: also accept -1 steps and add output dir.
//   clk, rst   : clock, asynchronous active-high reset
//   gray_in    : gray count, may be asynchronous to clk
//   bin_out    : registered binary of the synchronised value
//   bin_valid  : first post-reset sample has been decoded
//   step_pulse : one cycle per legal step
//   wrap_pulse : legal step across the all-ones/zero boundary
//   seq_err    : one cycle per illegal change
//   locked     : LOCK_COUNT consecutive legal steps seen, no error since
//   err_count  : saturating count of seq_err pulses
//   dir        : (GRAY_MON_DOWN_EN only) direction of last legal step, 1=down
module gray_sync_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_pulse,
  output logic                 wrap_pulse,
  output logic                 seq_err,
  output logic                 locked,
`ifdef GRAY_MON_DOWN_EN
  output logic                 dir,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned FillW = $clog2(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [ERR_CNT_W-1:0] ErrMax = ERR_CNT_W'(err_cnt_max(ERR_CNT_W));

  mon_state_e       state_q;
  logic [GoodW-1:0] good_q;
  logic [FillW-1:0] fill_q;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] d;
  logic             is_hold, is_up, is_legal, is_wrap;

  gray_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (g_s)
  );

  assign d       = WIDTH'(gray2bin(MaxWidth'(g_s)));
  assign is_hold = (d == bin_out);
  assign is_up   = (d == bin_out + WIDTH'(1));

`ifdef GRAY_MON_DOWN_EN
  logic is_down;
  assign is_down  = (d == bin_out - WIDTH'(1));
  assign is_legal = is_up | is_down;
  assign is_wrap  = is_up ? (bin_out == AllOnes) : (bin_out == '0);
`else
  assign is_legal = is_up;
  assign is_wrap  = (bin_out == AllOnes);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAcquire;
      good_q     <= '0;
      fill_q     <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
`ifdef GRAY_MON_DOWN_EN
      dir        <= 1'b0;
`endif
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      seq_err    <= 1'b0;
      bin_out    <= d;
      unique case (state_q)
        // Wait until the first post-reset sample has crossed the chain, so
        // the reset zeros in the sync flops are never judged as a jump.
        StAcquire: begin
          if (fill_q == FillW'(SYNC_STAGES)) begin
            bin_valid <= 1'b1;
            good_q    <= '0;
            state_q   <= StVerify;
          end else begin
            fill_q <= fill_q + FillW'(1);
          end
        end
        StVerify, StLocked: begin
          if (is_legal) begin
            step_pulse <= 1'b1;
            wrap_pulse <= is_wrap;
`ifdef GRAY_MON_DOWN_EN
            dir        <= is_down;
`endif
            if (state_q == StVerify) begin
              if (good_q == GoodW'(LOCK_COUNT - 1)) begin
                state_q <= StLocked;
                locked  <= 1'b1;
              end else begin
                good_q <= good_q + GoodW'(1);
              end
            end
          end else if (!is_hold) begin
            seq_err <= 1'b1;
            good_q  <= '0;
            locked  <= 1'b0;
            state_q <= StVerify;
            if (err_count != ErrMax) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
          end
        end
        default: state_q <= StAcquire;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sync_monitor.sv
module tb_gray_sync_monitor;

  localparam int W = 3;
  localparam int SS = 2;
  localparam int LC = 4;
  localparam int EW = 2;
  localparam int Mask = (1 << W) - 1;
  localparam int ErrMax = (1 << EW) - 1;
`ifdef GRAY_MON_DOWN_EN
  localparam bit DownEn = 1'b1;
`else
  localparam bit DownEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic [W-1:0]  bin_out;
  logic          bin_valid, step_pulse, wrap_pulse, seq_err, locked;
  logic [EW-1:0] err_count;
`ifdef GRAY_MON_DOWN_EN
  logic          dir;
`endif

  int errors = 0;
  int checks = 0;

  gray_sync_monitor #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .LOCK_COUNT  (LC),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .seq_err    (seq_err),
    .locked     (locked),
`ifdef GRAY_MON_DOWN_EN
    .dir        (dir),
`endif
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic int g2b(int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b & Mask;
  endfunction

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & Mask;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge n after reset release sees the gray value that was
  // sampled SS edges earlier; before that the chain still holds zeros.
  int  n = 0;
  int  samp[$];
  int  m_bin = 0, m_good = 0, m_errs = 0;
  bit  m_valid = 0, m_step = 0, m_wrap = 0, m_err = 0, m_locked = 0, m_dir = 0;

  always @(posedge clk or posedge rst) begin
    int d, diff;
    if (rst) begin
      n = 0;
      samp.delete();
      m_bin = 0; m_good = 0; m_errs = 0;
      m_valid = 0; m_step = 0; m_wrap = 0; m_err = 0; m_locked = 0; m_dir = 0;
    end else begin
      n++;
      samp.push_back(int'(gray_in));
      m_step = 0; m_wrap = 0; m_err = 0;
      d = (n > SS) ? g2b(samp[n-1-SS]) : 0;
      if (n == SS + 1) begin
        m_valid = 1;
        m_good  = 0;
      end else if (n > SS + 1) begin
        diff = (d - m_bin) & Mask;
        if (diff == 1 || (DownEn && diff == Mask)) begin
          m_step = 1;
          m_wrap = (diff == 1) ? (d == 0) : (d == Mask);
          m_dir  = (diff == Mask);
          if (!m_locked) begin
            m_good++;
            if (m_good == LC) m_locked = 1;
          end
        end else if (diff != 0) begin
          m_err = 1;
          m_good = 0;
          m_locked = 0;
          if (m_errs < ErrMax) m_errs++;
        end
      end
      m_bin = d;
    end
  end

  // Observed pulse tallies, used by the directed checks.
  int step_seen = 0, wrap_seen = 0, err_seen = 0, both_seen = 0;

  always @(posedge clk) begin
    #2;
    chk("bin_out", int'(bin_out), m_bin);
    chk("bin_valid", int'(bin_valid), int'(m_valid));
    chk("step_pulse", int'(step_pulse), int'(m_step));
    chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    chk("seq_err", int'(seq_err), int'(m_err));
    chk("locked", int'(locked), int'(m_locked));
    chk("err_count", int'(err_count), m_errs);
    chk("step_err_excl", int'(step_pulse & seq_err), 0);
`ifdef GRAY_MON_DOWN_EN
    chk("dir", int'(dir), int'(m_dir));
`endif
    step_seen += int'(step_pulse);
    wrap_seen += int'(wrap_pulse);
    err_seen  += int'(seq_err);
    both_seen += int'(step_pulse & wrap_pulse);
  end

  task automatic drive_bin(int b, int cyc);
    @(negedge clk);
    gray_in = W'(b2g(b));
    repeat (cyc - 1) @(negedge clk);
  endtask

  initial begin
    int s0, w0, e0, b0, cur, r, hold;
    int seq_up[6];
    int bad[5];
    seq_up = '{2, 3, 4, 5, 6, 7};
    bad    = '{5, 0, 3, 6, 1};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_bin_valid", int'(bin_valid), 0);
    chk("rst_locked", int'(locked), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("acq_valid", int'(bin_valid), 1);

    // Latency: change before edge 1, visible on bin_out after edge SS+1.
    gray_in = W'(1);
    repeat (SS) @(posedge clk);
    #1 chk("latency_early", int'(bin_out), 0);
    @(posedge clk);
    #1 chk("latency_on", int'(bin_out), 1);
    chk("latency_step", int'(step_pulse), 1);
    repeat (8) @(negedge clk);
    chk("lock_after_1", int'(locked), 0);

    foreach (seq_up[i]) begin
      drive_bin(seq_up[i], 10);
      chk("lock_progress", int'(locked), int'(seq_up[i] >= 4));
    end
    chk("up_bin7", int'(bin_out), 7);
    chk("up_errs", int'(err_count), 0);

    w0 = wrap_seen; b0 = both_seen;
    drive_bin(0, 10);
    chk("wrap_count", wrap_seen - w0, 1);
    chk("wrap_with_step", both_seen - b0, 1);
    chk("wrap_locked", int'(locked), 1);

    drive_bin(1, 10);
    drive_bin(2, 10);
    e0 = err_seen;
    drive_bin(6, 10);
    chk("jump_err_pulses", err_seen - e0, 1);
    chk("jump_err_count", int'(err_count), 1);
    chk("jump_unlocked", int'(locked), 0);
    chk("jump_bin", int'(bin_out), 6);

    drive_bin(7, 10);
    drive_bin(0, 10);
    drive_bin(1, 10);
    chk("relock_pending", int'(locked), 0);
    drive_bin(2, 10);
    chk("relock", int'(locked), 1);

    s0 = step_seen; w0 = wrap_seen; e0 = err_seen;
    repeat (100) @(negedge clk);
    chk("hold_steps", step_seen - s0, 0);
    chk("hold_wraps", wrap_seen - w0, 0);
    chk("hold_errs", err_seen - e0, 0);
    chk("hold_bin", int'(bin_out), 2);

    foreach (bad[i]) drive_bin(bad[i], 10);
    chk("err_saturate", int'(err_count), ErrMax);

    @(negedge clk);
    rst = 1'b1;
    gray_in = W'(6);
    #1;
    chk("midrst_bin", int'(bin_out), 0);
    chk("midrst_errs", int'(err_count), 0);
    chk("midrst_valid", int'(bin_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    e0 = err_seen;
    repeat (SS + 3) @(negedge clk);
    chk("release_bin", int'(bin_out), 4);
    chk("release_valid", int'(bin_valid), 1);
    chk("release_no_err", err_seen - e0, 0);

    s0 = step_seen;
    drive_bin(3, 10);
`ifdef GRAY_MON_DOWN_EN
    chk("down_step", step_seen - s0, 1);
    chk("down_dir", int'(dir), 1);
`else
    chk("down_is_err", int'(err_count), 1);
`endif

    // Randomised phase: mostly +1 steps with holds, some down steps, jumps
    // and occasional resets; every cycle is checked against the model.
    cur = 3;
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 6);
      if (r < 96) begin
        if (r < 70) cur = (cur + 1) & Mask;
        else if (r < 82) cur = (cur - 1) & Mask;
        else if (r < 96) cur = $urandom_range(0, Mask);
        drive_bin(cur, hold);
      end else begin
        @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
